// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the register-file writeback path
// Purpose: register address width, register count, the zero register and the
//          default queued writeback entry type.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int RF_DATA_W  = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - long-latency writeback result queue
// Purpose: DEPTH-entry FIFO of writeback entries with registered occupancy.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears pointers and count)
//   push, wr_entry  enqueue; caller guarantees !full
//   pop,  rd_entry  dequeue; rd_entry is the current head, caller guarantees !empty
//   count           occupancy, 0..DEPTH
//   full, empty     decoded from count
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 wr_entry,
  input  logic                   pop,
  output entry_t                 rd_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reset empties the queue through the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];
  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - register-file write port arbiter with busy scoreboard
// Purpose: merges single-cycle ALU results with queued long-latency results into
//          at most one registered register-file write per cycle, and tracks which
//          registers still await a long-latency result.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data      single-cycle result, always accepted, wins the port
//   ll_valid/ll_ready/ll_rd/ll_data long-latency result handshake into the queue
//   issue_valid/issue_long/issue_rd issuing instruction; long ones reserve their rd
//   chk_rs1/chk_rs2                decode-stage sources checked against the scoreboard
//   stall                          combinational hazard indication
//   RegWrite/rd_addr/write_data    registered write port of the register file
//   pending_cnt                    queue occupancy
module rf_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [REG_ADDR_W-1:0]  alu_rd,
  input  logic [N-1:0]           alu_data,
  input  logic                   ll_valid,
  output logic                   ll_ready,
  input  logic [REG_ADDR_W-1:0]  ll_rd,
  input  logic [N-1:0]           ll_data,
  input  logic                   issue_valid,
  input  logic                   issue_long,
  input  logic [REG_ADDR_W-1:0]  issue_rd,
  input  logic [REG_ADDR_W-1:0]  chk_rs1,
  input  logic [REG_ADDR_W-1:0]  chk_rs2,
  output logic                   stall,
  output logic                   RegWrite,
  output logic [REG_ADDR_W-1:0]  rd_addr,
  output logic [N-1:0]           write_data,
  output logic [$clog2(DEPTH):0] pending_cnt
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [N-1:0]          data;
  } entry_t;

  entry_t                q_in;
  entry_t                q_head;
  logic                  q_push;
  logic                  q_pop;
  logic                  q_full;
  logic                  q_empty;
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;

  assign q_in.rd   = ll_rd;
  assign q_in.data = ll_data;

  // ll_ready comes from the registered count only, so a dequeue while full
  // cannot open the queue in the same cycle.
  assign ll_ready = ~q_full;
  assign q_push   = ll_valid & ll_ready;
  // The queue only drains in cycles without ALU traffic.
  assign q_pop    = ~alu_valid & ~q_empty;

  rf_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (q_push),
    .wr_entry (q_in),
    .pop      (q_pop),
    .rd_entry (q_head),
    .count    (pending_cnt),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Set after clear so a register reserved and released in the same cycle
  // stays busy; x0 is never tracked.
  always_comb begin
    busy_next = busy;
    if (q_pop) busy_next[q_head.rd] = 1'b0;
    if (issue_valid && issue_long) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite   <= 1'b0;
      rd_addr    <= '0;
      write_data <= '0;
      busy       <= '0;
    end else begin
      // A winner targeting x0 still uses its slot but never writes.
      if (alu_valid) begin
        RegWrite   <= (alu_rd != ZERO_REG);
        rd_addr    <= alu_rd;
        write_data <= alu_data;
      end else if (q_pop) begin
        RegWrite   <= (q_head.rd != ZERO_REG);
        rd_addr    <= q_head.rd;
        write_data <= q_head.data;
      end else begin
        RegWrite   <= 1'b0;
      end
      busy <= busy_next;
    end
  end

  // The issuing rd is included so a second long op cannot overtake a pending write.
  assign stall = busy[chk_rs1] | busy[chk_rs2] | (issue_valid & busy[issue_rd]);

  // Upstream contract checks.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(issue_valid && stall));
      assert (!(alu_valid && busy[alu_rd]));
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - self-checking bench for rf_writeback_ctrl
module tb_rf_writeback_ctrl;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [N-1:0]  alu_data;
  logic          ll_valid;
  logic          ll_ready;
  logic [4:0]    ll_rd;
  logic [N-1:0]  ll_data;
  logic          issue_valid;
  logic          issue_long;
  logic [4:0]    issue_rd;
  logic [4:0]    chk_rs1;
  logic [4:0]    chk_rs2;
  logic          stall;
  logic          RegWrite;
  logic [4:0]    rd_addr;
  logic [N-1:0]  write_data;
  logic [CW-1:0] pending_cnt;

  int checks = 0;
  int errors = 0;

  rf_writeback_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ll_valid    (ll_valid),
    .ll_ready    (ll_ready),
    .ll_rd       (ll_rd),
    .ll_data     (ll_data),
    .issue_valid (issue_valid),
    .issue_long  (issue_long),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .stall       (stall),
    .RegWrite    (RegWrite),
    .rd_addr     (rd_addr),
    .write_data  (write_data),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending results, a busy set, and the last write.
  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } ent_t;

  ent_t         m_q[$];
  logic [31:0]  m_busy;
  logic         m_we;
  logic [4:0]   m_addr;
  logic [N-1:0] m_data;

  function automatic bit m_stall();
    return m_busy[chk_rs1] | m_busy[chk_rs2] | (issue_valid & m_busy[issue_rd]);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    issue_valid = 0; issue_long = 0; issue_rd = 0;
    chk_rs1 = 0; chk_rs2 = 0;
  endtask

  // Advance the model by one clock using the current inputs, then step the DUT
  // and leave time 1 unit after the edge.
  task automatic cycle();
    ent_t h;
    bit   push;
    push = rst && ll_valid && (m_q.size() != DEPTH);
    if (rst) begin
      if (alu_valid) begin
        m_we = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
      end else if (m_q.size() != 0) begin
        h = m_q.pop_front();
        m_we = (h.rd != 0); m_addr = h.rd; m_data = h.data;
        m_busy[h.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (issue_valid && issue_long) m_busy[issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (push) m_q.push_back('{rd: ll_rd, data: ll_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #2;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b exp 0", RegWrite); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr); end
    checks++; if (write_data !== '0) begin errors++; $display("FAIL reset_data: got %h exp 0", write_data); end
    checks++; if (pending_cnt !== '0) begin errors++; $display("FAIL reset_pending: got %0d exp 0", pending_cnt); end
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL reset_ll_ready: got %b exp 1", ll_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stall); end
    model_clear();
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  task automatic test_alu_only();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %b exp 1", RegWrite); end
    checks++; if (rd_addr !== 5'd5) begin errors++; $display("FAIL alu_rd_addr: got %0d exp 5", rd_addr); end
    checks++; if (write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_data: got %h exp deadbeef", write_data); end
    cycle();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL alu_single_pulse: got %b exp 0", RegWrite); end
  endtask

  task automatic test_long_latency();
    issue_valid = 1; issue_long = 1; issue_rd = 7;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL issue_stall: got %b exp 0", stall); end
    cycle();
    idle();
    chk_rs1 = 7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL busy_stall: got %b exp 1", stall); end
    ll_valid = 1; ll_rd = 7; ll_data = 32'h11;
    cycle();
    ll_valid = 0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL ll_t1_regwrite: got %b exp 0", RegWrite); end
    checks++; if (pending_cnt !== CW'(1)) begin errors++; $display("FAIL ll_t1_pending: got %0d exp 1", pending_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ll_t1_stall: got %b exp 1", stall); end
    cycle();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL ll_t2_regwrite: got %b exp 1", RegWrite); end
    checks++; if (rd_addr !== 5'd7) begin errors++; $display("FAIL ll_t2_rd_addr: got %0d exp 7", rd_addr); end
    checks++; if (write_data !== 32'h11) begin errors++; $display("FAIL ll_t2_data: got %h exp 11", write_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ll_t2_stall: got %b exp 0", stall); end
    idle();
  endtask

  task automatic test_order();
    logic [4:0] exp_rd [5];
    exp_rd[0] = 9; exp_rd[1] = 10; exp_rd[2] = 11; exp_rd[3] = 3; exp_rd[4] = 4;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 3) begin alu_valid = 1; alu_rd = 5'(9 + i); alu_data = 32'(1000 + i); end
      if (i < 2) begin ll_valid = 1; ll_rd = 5'(3 + i); ll_data = 32'(2000 + i); end
      cycle();
      if (i < 5) begin
        checks++; if (RegWrite !== 1'b1 || rd_addr !== exp_rd[i]) begin
          errors++; $display("FAIL order_%0d: got we=%b rd=%0d exp we=1 rd=%0d", i, RegWrite, rd_addr, exp_rd[i]);
        end
        checks++; if (write_data !== ((i < 3) ? 32'(1000 + i) : 32'(2000 + i - 3))) begin
          errors++; $display("FAIL order_data_%0d: got %0d", i, write_data);
        end
      end else begin
        checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL order_idle: got %b exp 0", RegWrite); end
      end
    end
    idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      alu_valid = 1; alu_rd = 5'(i + 1); alu_data = 32'(i);
      ll_valid = 1; ll_rd = 5'(12 + i); ll_data = 32'(100 + i);
      cycle();
    end
    checks++; if (pending_cnt !== CW'(DEPTH)) begin errors++; $display("FAIL full_pending: got %0d exp %0d", pending_cnt, DEPTH); end
    checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL full_ll_ready: got %b exp 0", ll_ready); end
    alu_valid = 0; ll_rd = 20; ll_data = 200;
    #1;
    checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL full_same_cycle_ready: got %b exp 0", ll_ready); end
    cycle();
    ll_valid = 0;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL drain_ll_ready: got %b exp 1", ll_ready); end
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) cycle();
      checks++; if (RegWrite !== 1'b1 || rd_addr !== 5'(12 + i) || write_data !== 32'(100 + i)) begin
        errors++; $display("FAIL drain_%0d: got we=%b rd=%0d data=%0d exp rd=%0d", i, RegWrite, rd_addr, write_data, 12 + i);
      end
      checks++; if (pending_cnt !== CW'(DEPTH - 1 - i)) begin
        errors++; $display("FAIL drain_cnt_%0d: got %0d exp %0d", i, pending_cnt, DEPTH - 1 - i);
      end
    end
    cycle();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL drain_end: got %b exp 0", RegWrite); end
    idle();
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    cycle();
    idle();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_alu: got %b exp 0", RegWrite); end
    ll_valid = 1; ll_rd = 0; ll_data = 32'h66;
    cycle();
    ll_rd = 6; ll_data = 32'h77;
    checks++; if (pending_cnt !== CW'(1)) begin errors++; $display("FAIL x0_queued: got %0d exp 1", pending_cnt); end
    cycle();
    ll_valid = 0;
    checks++; if (RegWrite !== 1'b0 || pending_cnt !== CW'(1)) begin
      errors++; $display("FAIL x0_dequeue: got we=%b cnt=%0d exp we=0 cnt=1", RegWrite, pending_cnt);
    end
    cycle();
    checks++; if (RegWrite !== 1'b1 || rd_addr !== 5'd6 || write_data !== 32'h77) begin
      errors++; $display("FAIL x0_next: got we=%b rd=%0d data=%h exp we=1 rd=6 data=77", RegWrite, rd_addr, write_data);
    end
    issue_valid = 1; issue_long = 1; issue_rd = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_issue_stall: got %b exp 0", stall); end
    cycle();
    idle();
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_busy_stall: got %b exp 0", stall); end
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_long = 1; issue_rd = 8;
    cycle();
    issue_rd = 9;
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 1; alu_data = 32'(i);
      ll_valid = 1; ll_rd = (i == 2) ? 5'd13 : 5'(8 + i); ll_data = 32'(300 + i);
      cycle();
    end
    idle();
    chk_rs1 = 8;
    #1;
    checks++; if (pending_cnt !== CW'(3) || RegWrite !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got cnt=%0d we=%b stall=%b exp cnt=3 we=1 stall=1", pending_cnt, RegWrite, stall);
    end
    rst = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0 || rd_addr !== 5'd0 || write_data !== '0) begin
      errors++; $display("FAIL mid_reset_out: got we=%b rd=%0d data=%h exp 0", RegWrite, rd_addr, write_data);
    end
    checks++; if (pending_cnt !== '0 || ll_ready !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: got cnt=%0d ready=%b stall=%b exp 0/1/0", pending_cnt, ll_ready, stall);
    end
    model_clear();
    idle();
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (RegWrite !== 1'b0 || pending_cnt !== '0) begin
        errors++; $display("FAIL post_reset_%0d: got we=%b cnt=%0d exp 0", i, RegWrite, pending_cnt);
      end
    end
  endtask

  task automatic test_random();
    int outst[$];
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom % 3) == 0;
      alu_rd    = 5'($urandom_range(0, 31));
      if (m_busy[alu_rd]) alu_rd = 0;
      alu_data  = $urandom;
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      issue_valid = ($urandom % 2) == 0;
      issue_long  = ($urandom % 2) == 0;
      issue_rd    = 5'($urandom_range(0, 31));
      if (m_stall()) issue_valid = 0;
      ll_valid = ($urandom % 2) == 0;
      if (outst.size() > 0 && ($urandom % 4) != 0) ll_rd = 5'(outst[0]);
      else ll_rd = 5'($urandom_range(0, 31));
      ll_data = $urandom;
      #1;
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall_%0d: got %b exp %b", i, stall, m_stall()); end
      if (ll_valid && m_q.size() != DEPTH && outst.size() > 0 && ll_rd == 5'(outst[0])) void'(outst.pop_front());
      if (issue_valid && issue_long && issue_rd != 0) outst.push_back(int'(issue_rd));
      cycle();
      checks++; if (RegWrite !== m_we) begin errors++; $display("FAIL rnd_we_%0d: got %b exp %b", i, RegWrite, m_we); end
      if (m_we) begin
        checks++; if (rd_addr !== m_addr || write_data !== m_data) begin
          errors++; $display("FAIL rnd_write_%0d: got rd=%0d data=%h exp rd=%0d data=%h", i, rd_addr, write_data, m_addr, m_data);
        end
      end
      checks++; if (pending_cnt !== CW'(m_q.size()) || ll_ready !== (m_q.size() != DEPTH)) begin
        errors++; $display("FAIL rnd_queue_%0d: got cnt=%0d ready=%b exp cnt=%0d", i, pending_cnt, ll_ready, m_q.size());
      end
    end
    idle();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alu_only();
    test_long_latency();
    test_order();
    test_full();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
